vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port 16 KB video RAM between the VGA scanout read path and
//  the HPS ioctl download write path inside the SoC. Scanout reads have strict
//  priority with a fixed 2-cycle latency. Download writes are buffered in a small
//  FIFO and committed only in free RAM slots. Also drives the download 'progress'
//  indicator and a committed-write counter.
// PARAMETERS
//  FIFO_DEPTH     8     write FIFO entries (power of 2, >=2)
//  IDLE_TIMEOUT   1024  cycles with no ioctl_wr and an empty FIFO before progress drops
//  STARVE_LIMIT   64    max wait of the FIFO head before it takes a slot (fairness only)
// PORTS
//  pixel_clock   in   1   sole clock
//  reset_n       in   1   asynchronous reset, active low
//  ioctl_wr      in   1   one-cycle write strobe from HPS download
//  ioctl_addr    in   14  write address
//  ioctl_data    in   8   write data
//  vid_rd_req    in   1   scanout read request, one per cycle max
//  vid_rd_addr   in   14  scanout read address
//  vid_rd_data   out  8   read data, equals ram_rdata while vid_rd_valid=1
//  vid_rd_valid  out  1   read data valid
//  vid_rd_stall  out  1   read request displaced by a fairness write (fairness only)
//  ram_addr      out  14  RAM address, registered
//  ram_we        out  1   RAM write enable, registered
//  ram_wdata     out  8   RAM write data, registered
//  ram_rdata     in   8   RAM read data, 1-cycle latency after ram_addr
//  progress      out  1   download in progress
//  overflow      out  1   sticky: an ioctl write was dropped (FIFO full)
//  wr_count      out  15  writes committed since progress last rose
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; timers and counters cleared. Reset mid-download
//   discards FIFO contents with no partial RAM write.
//  Grant, evaluated every cycle on the sampled inputs:
//   vid_rd_req=1 -> read slot: ram_addr<=vid_rd_addr, ram_we<=0.
//   else FIFO non-empty -> write slot: pop head, ram_addr/ram_wdata<=head, ram_we<=1.
//   else ram_we<=0 and ram_addr holds its value.
//  Read latency: request sampled at edge N -> ram_addr valid after N+1 ->
//   vid_rd_valid=1 after N+2 for exactly one cycle, vid_rd_data=ram_rdata.
//   Back-to-back requests are fully pipelined.
//  FIFO push: on ioctl_wr when not full, or when full with a pop in the same cycle.
//   Otherwise the write is dropped and overflow is set. Order preserved (FIFO).
//  Pop and push in the same cycle on an empty FIFO: no bypass, entry is written
//   at the earliest next free slot.
//  progress: set on the cycle after any ioctl_wr (accepted or dropped). A 0->1
//   transition clears wr_count. Idle counter is reset by ioctl_wr and counts while
//   the FIFO is empty; progress clears when it reaches IDLE_TIMEOUT.
//  wr_count: +1 per committed RAM write, saturates at 16384.
// CONFIGURATION
//  VRAM_ARB_FAIRNESS_EN defined:
//   - age counter runs while the FIFO head waits; resets on pop.
//   - when age=STARVE_LIMIT the write wins even if vid_rd_req=1.
//   - that read is not issued; vid_rd_stall=1 for one cycle, aligned with where
//     vid_rd_valid would have been (N+2), with vid_rd_valid=0 there.
//  Not defined:
//   - strict read priority; writes can wait indefinitely.
//   - vid_rd_stall tied 0.
// TESTING
//  1. Reset release, 3 ioctl_wr (0x0000=AA, 0x0001=BB, 0x3FFF=CC), vid_rd_req=0
//     -> 3 ram_we pulses, same order/values; wr_count=3; progress=1 until
//     IDLE_TIMEOUT cycles after last write, then 0.
//  2. vid_rd_req held 1 for 20 cycles, addrs 0..19, with 2 ioctl writes queued
//     -> vid_rd_valid every cycle from 2 cycles after the first request; no ram_we
//     until the request drops, then both writes in the next 2 cycles.
//  3. vid_rd_req held 1, FIFO_DEPTH+2 ioctl_wr
//     -> exactly FIFO_DEPTH buffered, overflow=1 and stays 1; later drains
//     FIFO_DEPTH writes.
//  4. FIFO full, ioctl_wr in the same cycle as a pop -> accepted, overflow stays 0.
//  5. Fairness build, vid_rd_req held 1, one write
//     -> write commits when age hits STARVE_LIMIT; vid_rd_stall=1 for one cycle,
//     2 cycles later; all other reads valid.
//  6. reset_n pulsed low with 4 writes queued -> all outputs 0 asynchronously;
//     no ram_we after release.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the video RAM arbiter and the SoC side (HPS download, scanout, RAM).
// The slave modport is the arbiter; the master modport is everything around it.
interface vram_arbiter_if;
    logic        ioctl_wr;
    logic [13:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        vid_rd_req;
    logic [13:0] vid_rd_addr;
    logic [7:0]  vid_rd_data;
    logic        vid_rd_valid;
    logic        vid_rd_stall;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        progress;
    logic        overflow;
    logic [14:0] wr_count;

    modport slave (
        input  ioctl_wr, ioctl_addr, ioctl_data, vid_rd_req, vid_rd_addr, ram_rdata,
        output vid_rd_data, vid_rd_valid, vid_rd_stall, ram_addr, ram_we, ram_wdata,
        output progress, overflow, wr_count
    );

    modport master (
        output ioctl_wr, ioctl_addr, ioctl_data, vid_rd_req, vid_rd_addr, ram_rdata,
        input  vid_rd_data, vid_rd_valid, vid_rd_stall, ram_addr, ram_we, ram_wdata,
        input  progress, overflow, wr_count
    );
endinterface

// File: rtl/vram_arbiter.sv
// Purpose: share one single-port VRAM between scanout reads (priority) and buffered download writes.
// Latency: read data valid 2 cycles after the request; writes commit in the first free slot.
// Backpressure: none toward scanout; download writes dropped when the FIFO is full (sticky overflow).
// Optional VRAM_ARB_FAIRNESS_EN: a write that waited STARVE_LIMIT cycles displaces one read.
module vram_arbiter #(
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_TIMEOUT = 1024
`ifdef VRAM_ARB_FAIRNESS_EN
    ,
    parameter int STARVE_LIMIT = 64
`endif
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    vram_arbiter_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [14:0] WR_SAT = 15'd16384;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_ent_t;

    wr_ent_t       fifo_q [FIFO_DEPTH];
    wr_ent_t       head;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fifo_empty, fifo_full, fair_win, rd_grant, pop, push;

    logic [13:0]   ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          rd_p1_q, rd_vld_q;
    logic          progress_q, progress_d;
    logic          overflow_q, overflow_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [14:0]   wr_count_q, wr_count_d;

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign rd_grant   = bus.vid_rd_req && !fair_win;
    assign pop        = !rd_grant && !fifo_empty;
    // A full FIFO still accepts when the head leaves in the same cycle; no bypass when empty.
    assign push       = bus.ioctl_wr && (!fifo_full || pop);

`ifdef VRAM_ARB_FAIRNESS_EN
    localparam int GW = $clog2(STARVE_LIMIT + 1);
    logic [GW-1:0] age_q, age_d;
    logic          st_p1_q, stall_q;

    assign fair_win = !fifo_empty && (age_q == GW'(STARVE_LIMIT));

    always_comb begin
        age_d = age_q;
        if (pop || fifo_empty)
            age_d = '0;
        else if (age_q != GW'(STARVE_LIMIT))
            age_d = age_q + GW'(1);
    end

    // Stall travels the same two stages as a read so it lands where the lost data would have.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            age_q   <= '0;
            st_p1_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            st_p1_q <= bus.vid_rd_req && fair_win;
            stall_q <= st_p1_q;
        end
    end

    assign bus.vid_rd_stall = stall_q;
`else
    assign fair_win         = 1'b0;
    assign bus.vid_rd_stall = 1'b0;
`endif

    always_comb begin
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (rd_grant) begin
            ram_addr_d = bus.vid_rd_addr;
        end else if (pop) begin
            ram_addr_d  = head.addr;
            ram_wdata_d = head.data;
            ram_we_d    = 1'b1;
        end
        overflow_d = overflow_q | (bus.ioctl_wr & ~push);
    end

    always_comb begin
        idle_d     = idle_q;
        progress_d = progress_q;
        if (bus.ioctl_wr) begin
            idle_d     = '0;
            progress_d = 1'b1;
        end else if (fifo_empty) begin
            if (idle_q != IW'(IDLE_TIMEOUT))
                idle_d = idle_q + IW'(1);
            if (idle_d == IW'(IDLE_TIMEOUT))
                progress_d = 1'b0;
        end
        wr_count_d = wr_count_q;
        if (pop && wr_count_q != WR_SAT)
            wr_count_d = wr_count_q + 15'd1;
        if (!progress_q && progress_d)
            wr_count_d = '0;
    end

    always_ff @(posedge pixel_clock) begin
        if (push)
            fifo_q[wr_ptr_q] <= {bus.ioctl_addr, bus.ioctl_data};
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            progress_q  <= 1'b0;
            overflow_q  <= 1'b0;
            idle_q      <= '0;
            wr_count_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd_p1_q     <= rd_grant;
            rd_vld_q    <= rd_p1_q;
            progress_q  <= progress_d;
            overflow_q  <= overflow_d;
            idle_q      <= idle_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.vid_rd_valid = rd_vld_q;
    assign bus.vid_rd_data  = rd_vld_q ? bus.ram_rdata : 8'h00;
    assign bus.progress     = progress_q;
    assign bus.overflow     = overflow_q;
    assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_vram_arbiter;
    localparam int FD = 8;
    localparam int IT = 1024;
    localparam int SL = 64;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk;
    logic rst_n;
    vram_arbiter_if bus();

    vram_arbiter #(.FIFO_DEPTH(FD), .IDLE_TIMEOUT(IT)) dut (
        .pixel_clock(clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16384];
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the RAM port and status outputs must be from the arbitration rules.
    logic [7:0]  mm [16384];
    wr_t         mq[$];
    int          age, idle, exp_cnt;
    bit          exp_we, exp_prog, exp_ovf, exp_valid, exp_stall, p1_v, p1_s;
    logic [13:0] exp_addr;
    logic [7:0]  exp_wdata, exp_data, p1_d;

    task automatic model_reset();
        mq.delete();
        age = 0; idle = 0; exp_cnt = 0;
        exp_we = 0; exp_prog = 0; exp_ovf = 0; exp_valid = 0; exp_stall = 0;
        p1_v = 0; p1_s = 0; p1_d = 0;
        exp_addr = 0; exp_wdata = 0; exp_data = 0;
    endtask

    task automatic model_step();
        bit emp, full, fair, rd, wslot, prev;
        wr_t h, n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        emp  = (mq.size() == 0);
        full = (mq.size() == FD);
        fair = 0;
`ifdef VRAM_ARB_FAIRNESS_EN
        fair = !emp && (age == SL);
`endif
        rd    = bus.vid_rd_req && !fair;
        wslot = !rd && !emp;
        prev  = exp_prog;
        exp_valid = p1_v;
        exp_data  = p1_v ? p1_d : 8'h00;
        exp_stall = p1_s;
        p1_v = rd;
        p1_d = mm[bus.vid_rd_addr];
        p1_s = bus.vid_rd_req && fair;
        if (wslot) begin
            h = mq.pop_front();
            exp_we = 1; exp_addr = h.a; exp_wdata = h.d;
            mm[h.a] = h.d;
            if (exp_cnt < 16384) exp_cnt++;
            age = 0;
        end else begin
            exp_we = 0;
            if (rd) exp_addr = bus.vid_rd_addr;
            age = emp ? 0 : ((age < SL) ? age + 1 : age);
        end
        if (bus.ioctl_wr) begin
            if (!full || wslot) begin
                n.a = bus.ioctl_addr; n.d = bus.ioctl_data;
                mq.push_back(n);
            end else exp_ovf = 1;
            exp_prog = 1;
            idle = 0;
        end else if (emp) begin
            if (idle < IT) idle++;
            if (idle == IT) exp_prog = 0;
        end
        if (!prev && exp_prog) exp_cnt = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    wr_t        we_log[$];
    logic [7:0] rd_log[$];
    int         valid_cnt = 0;
    int         stall_cnt = 0;

    initial forever begin
        wr_t e;
        @(negedge clk);
        chk("ram_we",       32'(bus.ram_we),       32'(exp_we));
        chk("ram_addr",     32'(bus.ram_addr),     32'(exp_addr));
        chk("ram_wdata",    32'(bus.ram_wdata),    32'(exp_wdata));
        chk("vid_rd_valid", 32'(bus.vid_rd_valid), 32'(exp_valid));
        chk("vid_rd_data",  32'(bus.vid_rd_data),  32'(exp_data));
        chk("vid_rd_stall", 32'(bus.vid_rd_stall), 32'(exp_stall));
        chk("progress",     32'(bus.progress),     32'(exp_prog));
        chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
        chk("wr_count",     32'(bus.wr_count),     32'(exp_cnt));
        if (bus.ram_we === 1'b1) begin
            e.a = bus.ram_addr; e.d = bus.ram_wdata;
            we_log.push_back(e);
        end
        if (bus.vid_rd_valid === 1'b1) begin
            valid_cnt++;
            rd_log.push_back(bus.vid_rd_data);
        end
        if (bus.vid_rd_stall === 1'b1) stall_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wr, input logic [13:0] wa, input logic [7:0] wd,
                         input bit rq, input logic [13:0] ra);
        bus.ioctl_wr = wr; bus.ioctl_addr = wa; bus.ioctl_data = wd;
        bus.vid_rd_req = rq; bus.vid_rd_addr = ra;
    endtask

    task automatic chk_entry(input string name, input int idx, input logic [13:0] a, input logic [7:0] d);
        wr_t e;
        e.a = 'x; e.d = 'x;
        if (idx >= 0 && idx < we_log.size()) e = we_log[idx];
        chk({name, "_addr"}, 32'(e.a), 32'(a));
        chk({name, "_data"}, 32'(e.d), 32'(d));
    endtask

    int base, vbase, sbase, rbase;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 16384; i++) begin
            mem[i] <= 8'(i) ^ 8'h5A;
            mm[i]   = 8'(i) ^ 8'h5A;
        end
        repeat (3) tick();
        chk("reset_ram_we",   32'(bus.ram_we),   0);
        chk("reset_progress", 32'(bus.progress), 0);
        chk("reset_wr_count", 32'(bus.wr_count), 0);
        rst_n = 1'b1;
        tick();

        // Three downloads with no scanout
        drive(1, 14'h0000, 8'hAA, 0, 0); tick();
        drive(1, 14'h0001, 8'hBB, 0, 0); tick();
        drive(1, 14'h3FFF, 8'hCC, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t1_we_count", 32'(we_log.size()), 3);
        chk_entry("t1_w0", 0, 14'h0000, 8'hAA);
        chk_entry("t1_w1", 1, 14'h0001, 8'hBB);
        chk_entry("t1_w2", 2, 14'h3FFF, 8'hCC);
        chk("t1_wr_count", 32'(bus.wr_count), 3);
        repeat (IT - 3) tick();
        chk("t1_progress_hold", 32'(bus.progress), 1);
        tick();
        chk("t1_progress_drop", 32'(bus.progress), 0);

        // Scanout burst of 20 with two writes queued behind it
        base = we_log.size(); vbase = valid_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(i < 2, 14'h0100 + 14'(i), 8'h11 * 8'(i + 1), 1, 14'(i));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("t2_no_we_during_reads", 32'(we_log.size() - base), 0);
        repeat (3) tick();
        chk("t2_we_after", 32'(we_log.size() - base), 2);
        chk_entry("t2_w0", base, 14'h0100, 8'h11);
        chk_entry("t2_w1", base + 1, 14'h0101, 8'h22);
        chk("t2_valid_count", 32'(valid_cnt - vbase), 20);

        // Overflow: FIFO_DEPTH+2 writes while reads block the RAM
        base = we_log.size();
        for (int i = 0; i < FD + 2; i++) begin
            drive(1, 14'h0200 + 14'(i), 8'h30 + 8'(i), 1, 14'(i));
            tick();
        end
        drive(0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("t3_overflow", 32'(bus.overflow), 1);
        chk("t3_no_we", 32'(we_log.size() - base), 0);
        drive(0, 0, 0, 0, 0);
        repeat (12) tick();
        chk("t3_drained", 32'(we_log.size() - base), FD);
        chk_entry("t3_last", base + FD - 1, 14'h0207, 8'h37);
        chk("t3_overflow_sticky", 32'(bus.overflow), 1);

        // Asynchronous reset with four writes queued
        for (int i = 0; i < 4; i++) begin
            drive(1, 14'h0400 + 14'(i), 8'hE0 + 8'(i), 1, 14'(i));
            tick();
        end
        drive(0, 0, 0, 1, 0);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_overflow", 32'(bus.overflow), 0);
        chk("t6_rst_progress", 32'(bus.progress), 0);
        chk("t6_rst_valid",    32'(bus.vid_rd_valid), 0);
        chk("t6_rst_addr",     32'(bus.ram_addr), 0);
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        base = we_log.size();
        repeat (10) tick();
        chk("t6_no_we_after", 32'(we_log.size() - base), 0);

        // Full FIFO accepts a write in the same cycle as a pop
        base = we_log.size();
        for (int i = 0; i < FD; i++) begin
            drive(1, 14'h0300 + 14'(i), 8'h60 + 8'(i), 1, 14'(i));
            tick();
        end
        drive(1, 14'h0310, 8'h77, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (12) tick();
        chk("t4_overflow", 32'(bus.overflow), 0);
        chk("t4_drained", 32'(we_log.size() - base), FD + 1);
        chk_entry("t4_last", base + FD, 14'h0310, 8'h77);
        chk("t4_wr_count", 32'(bus.wr_count), FD + 1);

`ifdef VRAM_ARB_FAIRNESS_EN
        // Starved write displaces exactly one read
        base = we_log.size(); vbase = valid_cnt; sbase = stall_cnt;
        drive(1, 14'h0500, 8'h99, 1, 0);
        tick();
        for (int i = 1; i < 100; i++) begin
            drive(0, 0, 0, 1, 14'(i));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t5_stall_count", 32'(stall_cnt - sbase), 1);
        chk("t5_we_count", 32'(we_log.size() - base), 1);
        chk_entry("t5_w", base, 14'h0500, 8'h99);
        chk("t5_valid_count", 32'(valid_cnt - vbase), 99);
`endif

        // Read back committed data through the scanout path
        rbase = rd_log.size();
        drive(0, 0, 0, 1, 14'h0000); tick();
        drive(0, 0, 0, 1, 14'h3FFF); tick();
        drive(0, 0, 0, 1, 14'h0310); tick();
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t7_rd_count", 32'(rd_log.size() - rbase), 3);
        if (rd_log.size() >= rbase + 3) begin
            chk("t7_rd_0000", 32'(rd_log[rbase]),     32'h00AA);
            chk("t7_rd_3fff", 32'(rd_log[rbase + 1]), 32'h00CC);
            chk("t7_rd_0310", 32'(rd_log[rbase + 2]), 32'h0077);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
